// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  seq_pkg
//  Shared types and constants for the five-stage sequencer.
//  Revision: 1.0
// ============================================================================
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVERRUN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    function automatic logic [4:0] stage_onehot(input state_e s);
        case (s)
            S_FETCH:  return 5'b00001;
            S_DECODE: return 5'b00010;
            S_EXEC:   return 5'b00100;
            S_MEM:    return 5'b01000;
            S_WB:     return 5'b10000;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_watchdog.sv
`default_nettype none
// ============================================================================
//  stage_watchdog
//  Counts non-strobe cycles spent in one stage; flags the last allowed cycle.
//  Revision: 1.0
// ============================================================================
module stage_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of earlier non-strobe cycles, so this is the TIMEOUT-th one
    assign expired = enable && !clear && (count_q >= CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  stage_sequencer
//  Multi-cycle control FSM stepping fetch/decode/execute/memory/writeback.
//  Revision: 1.0
// ============================================================================
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W       = 4,
    parameter int IMEM_DEPTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      stage_done,
    input  logic            halt_req,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            stage1,
    output logic            stage2,
    output logic            stage3,
    output logic            stage4,
    output logic            stage5,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            halted,
    output logic [1:0]      error,
    output logic [7:0]      instr_count
);

    localparam logic [PC_W:0] PC_LIMIT = (PC_W + 1)'(IMEM_DEPTH);

    state_e          state_q, state_d;
    logic [4:0]      strobe_q, strobe_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            halt_lat_q, halt_lat_d;
    logic            br_lat_q, br_lat_d;
    logic [PC_W-1:0] br_tgt_q, br_tgt_d;
    logic            running_q, running_d;
    logic            halted_q, halted_d;

    logic            in_stage;
    logic            first_cycle;
    logic            own_done;
    logic            advance;
    logic            wd_clear;
    logic            wd_enable;
    logic            wd_expired;
    logic [PC_W:0]   next_pc;

    assign in_stage    = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
    assign first_cycle = |strobe_q;
    assign wd_clear    = !in_stage || first_cycle;
    assign wd_enable   = in_stage && !first_cycle;

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        own_done = 1'b0;
        case (state_q)
            S_FETCH:  own_done = stage_done[STG_IF];
            S_DECODE: own_done = stage_done[STG_ID];
            S_EXEC:   own_done = stage_done[STG_EX];
            S_MEM:    own_done = stage_done[STG_MEM];
            S_WB:     own_done = stage_done[STG_WB];
            default:  own_done = 1'b0;
        endcase
    end

    // Done is not honoured in the strobe cycle itself
    assign advance = own_done && !first_cycle;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        halt_lat_d = halt_lat_q;
        br_lat_d   = br_lat_q;
        br_tgt_d   = br_tgt_q;
        next_pc    = br_lat_q ? {1'b0, br_tgt_q} : ({1'b0, pc_q} + (PC_W + 1)'(1));

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d    = S_FETCH;
                    pc_d       = '0;
                    err_d      = ERR_NONE;
                    cnt_d      = '0;
                    halt_lat_d = 1'b0;
                    br_lat_d   = 1'b0;
                    br_tgt_d   = '0;
                end
            end
            S_FETCH: begin
                if (advance) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (advance) begin
                    state_d    = S_EXEC;
                    halt_lat_d = halt_req;
                end
            end
            S_EXEC: begin
                if (advance) begin
                    state_d  = S_MEM;
                    br_lat_d = branch_taken;
                    br_tgt_d = branch_target;
                end
            end
            S_MEM: begin
                if (advance) state_d = S_WB;
            end
            S_WB: begin
                if (advance) begin
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (halt_lat_q) begin
                        state_d = S_HALT;
                        err_d   = ERR_NONE;
                    end else if (next_pc >= PC_LIMIT) begin
                        state_d = S_HALT;
                        err_d   = ERR_OVERRUN;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = next_pc[PC_W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_stage && !advance && wd_expired) begin
            state_d = S_HALT;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_comb begin
        strobe_d  = (state_d != state_q) ? stage_onehot(state_d) : 5'b00000;
        running_d = state_d inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            strobe_q   <= '0;
            pc_q       <= '0;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            halt_lat_q <= 1'b0;
            br_lat_q   <= 1'b0;
            br_tgt_q   <= '0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            strobe_q   <= strobe_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            halt_lat_q <= halt_lat_d;
            br_lat_q   <= br_lat_d;
            br_tgt_q   <= br_tgt_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
        end
    end

    assign stage1      = strobe_q[STG_IF];
    assign stage2      = strobe_q[STG_ID];
    assign stage3      = strobe_q[STG_EX];
    assign stage4      = strobe_q[STG_MEM];
    assign stage5      = strobe_q[STG_WB];
    assign pc          = pc_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign error       = err_q;
    assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM that drives the processor's five stages (fetch, decode, execute, memory, writeback) one at a time. It owns the program counter, issues a one-cycle strobe to each stage, waits for that stage's done handshake, and applies branch and halt decisions. A per-stage watchdog guards against stalled stages. The PC output feeds the fetch stage's address input, and the `stage1` strobe triggers fetch.

## Interface
- `PC_W`, default 4: program counter width.
- `IMEM_DEPTH`, default 8: number of valid instruction words. Valid PCs are 0..IMEM_DEPTH-1.
- `TIMEOUT`, default 15: maximum cycles a stage may take after its strobe before it is declared stalled.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins a run from PC 0. Level-sampled; acts only in IDLE or HALT.
- `stage_done` input 5: bit i is completion of stage i+1.
- `halt_req` input 1: halt opcode decoded. Sampled with `stage_done[1]`.
- `branch_taken` input 1: sampled with `stage_done[2]`.
- `branch_target` input PC_W: sampled with `stage_done[2]`.
- `stage1`..`stage5` output 1 each: one-cycle strobe that opens the stage.
- `pc` output PC_W: current instruction address.
- `running` output 1: high in any stage state.
- `halted` output 1: high in HALT.
- `error` output 2: 0 none, 1 PC overrun, 2 stage timeout.
- `instr_count` output 8: retired instructions, saturating at 255.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async): state IDLE, `pc`=0, all strobes 0, `running`=0, `halted`=0, `error`=0, `instr_count`=0, latched halt and branch flags cleared.
- IDLE or HALT with `start`=1: clear `pc`, `error`, `instr_count` and the latches, then enter FETCH.
- `start` while running is ignored.
- On entry to each stage state, the matching strobe is high for exactly that first cycle.
- `stage_done` is ignored in the strobe cycle. From the next cycle, the state's own done bit advances it: FETCH→DECODE→EXEC→MEM→WB. Done bits for other stages are ignored.
- On DECODE done, latch `halt_req`. On EXEC done, latch `branch_taken` and `branch_target`.
- On WB done:
  - `instr_count` += 1, saturating at 255.
  - If the halt latch is set: enter HALT, `pc` unchanged, `error`=0.
  - Otherwise next PC = `branch_target` if the branch latch is set, else `pc`+1, computed in PC_W+1 bits.
  - If next PC ≥ IMEM_DEPTH: enter HALT with `error`=1 and `pc` unchanged.
  - Otherwise load `pc` and enter FETCH.
- Watchdog: counts cycles in the current stage state after the strobe cycle and resets on every state change. If it reaches TIMEOUT without done: enter HALT with `error`=2 and `pc` unchanged; the instruction does not retire.
- A done and a timeout in the same cycle: done wins.
- Reset mid-run returns immediately to the reset state, and no further strobe is issued.

## Timing
- `start` sampled high at edge N puts the FETCH state and `stage1` high in cycle N+1.
- With each done asserted in the cycle after its strobe, every stage takes 2 cycles, so an instruction takes 10 cycles.
- `pc` updates on the same edge that enters FETCH, so it is stable during the `stage1` cycle.
- `instr_count`, `halted` and `error` update on the WB-done (or timeout) edge.
- All outputs are registered.
- No combinational path from inputs to outputs.

## Structure
- Package `seq_pkg` holds:
  - the state enum;
  - the error code constants (ERR_NONE, ERR_OVERRUN, ERR_TIMEOUT);
  - the stage index constants (STG_IF=0 .. STG_WB=4).
- Sub-module `stage_watchdog`: a counter of width $clog2(TIMEOUT+1) with clear and enable inputs and an `expired` output.

## Test plan
- Reset and idle: assert `rst_n`=0 mid-cycle → all outputs 0 immediately. Release with `start`=0 → stays IDLE and no strobes.
- Straight-line run: `start`, done one cycle after each strobe, `halt_req` on the third DECODE → `pc` sequence 0,1,2. After the third WB, `halted`=1, `instr_count`=3, `error`=0, `pc`=2. `stage1` at cycles 1, 11, 21.
- Branch: branch_taken=1, target=5 on the first EXEC → second fetch at `pc`=5. With no branch on that instruction, the next fetch is at `pc`=6.
- Overrun: branch to 7, no halt → after WB of PC 7, `error`=1, `halted`=1, `pc`=7, `instr_count`=2.
- Timeout: withhold `stage_done[3]` → HALT with `error`=2 exactly TIMEOUT cycles after the cycle following the `stage4` strobe, and `instr_count` not incremented. Done asserted in the expiry cycle → advances to WB instead.
- Control edges:
  - `start` pulsed during EXEC → no effect.
  - `start` in HALT → restart at `pc`=0 with counters cleared.
  - `rst_n` low during MEM → IDLE, and no `stage5` is ever issued.
